mste_sysctrl: RTL
=================

MSTE_SYSCTRL -- requirements
Module: mste_sysctrl

Interface
REQ-001 SHALL have parameter NREGS, default 4, meaning number of 8-bit register slots; legal values 2..16.
REQ-002 SHALL have parameter SETTLE, default 4, meaning clock cycles the speed sequencer holds busy after a switch; legal values 1..255.
REQ-003 SHALL have port clk  input  1  system clock; all state changes on its rising edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port din  input  8  CPU write data.
REQ-006 SHALL have port addr  input  AW = max(1, clog2(NREGS))  register index.
REQ-007 SHALL have port sel  input  1  register access strobe; qualifies rw, addr and din.
REQ-008 SHALL have port rw  input  1  1 = read, 0 = write.
REQ-009 SHALL have port dout  output  8  read data.
REQ-010 SHALL have port bus_idle  input  1  CPU bus has no cycle in progress, so a clock switch is safe.
REQ-011 SHALL have port enable_16mhz  output  1  applied CPU speed.
REQ-012 SHALL have port enable_cache  output  1  cache enable.
REQ-013 SHALL have port cache_flush  output  1  one-cycle cache invalidate pulse.
REQ-014 SHALL have port speed_busy  output  1  speed switch pending or settling.

Function
REQ-015 SHALL implement reg0 as CTRL: bit0 = requested 16 MHz; bit1 = cache enable; bits 6:2 = stored and read back; bit7 = flush request, write-1 pulse, always reads 0.
REQ-016 SHALL implement reg1 as STATUS, read-only: bit0 = enable_16mhz, bit1 = speed_busy, bit2 = CTRL bit0, bits 7:3 = 0; writes to it are ignored.
REQ-017 SHALL implement reg2..NREGS-1 as 8-bit read/write scratch registers.
REQ-018 SHALL write the addressed register with din at the clock edge where sel=1 and rw=0.
REQ-019 SHALL drive dout combinationally with the addressed register when sel=1 and rw=1, and with 0 otherwise.
REQ-020 SHALL ignore writes to addr >= NREGS and return 0 on reads from it.
REQ-021 SHALL drive enable_cache directly from CTRL bit1, so it changes the cycle after the write.
REQ-022 SHALL assert cache_flush for exactly one cycle, the cycle after a CTRL write that either sets bit1 from 0 to 1 or has din[7]=1; one pulse only if both apply.
REQ-023 SHALL implement the speed sequencer as an FSM with states IDLE, WAIT_IDLE and SETTLE.
REQ-024 SHALL move the FSM from IDLE to WAIT_IDLE when CTRL bit0 differs from enable_16mhz.
REQ-025 SHALL, in WAIT_IDLE, return to IDLE with no output change when CTRL bit0 again equals enable_16mhz.
REQ-026 SHALL, in WAIT_IDLE, when bus_idle=1 and CTRL bit0 still differs, load enable_16mhz from the current CTRL bit0, load the counter with SETTLE-1 and enter SETTLE.
REQ-027 SHALL, in SETTLE, decrement the counter each cycle and return to IDLE on the cycle the counter is 0, giving exactly SETTLE cycles in SETTLE.
REQ-028 SHALL ignore CTRL changes made during SETTLE until the FSM is back in IDLE, then evaluate them per REQ-024.
REQ-029 SHALL drive speed_busy = 1 whenever the FSM is not in IDLE.

Reset
REQ-030 SHALL, while reset_n=0 and independent of clk, clear all registers, set the FSM to IDLE and the counter to 0, and drive enable_16mhz, enable_cache, cache_flush and speed_busy to 0.
REQ-031 SHALL abandon an in-flight switch on reset, so no flush pulse and no speed change occurs after reset_n releases.

Structure
REQ-032 SHALL place the register indices (CTRL=0, STATUS=1), the CTRL/STATUS bit positions and the FSM state encoding in the shared package mste_pkg.
REQ-033 SHALL implement the speed FSM and its counter as the single sub-module mste_speed_seq; the register bank and the flush logic stay in the top module.

Verification
REQ-034 SHALL verify reset: assert reset_n low mid-SETTLE -> all outputs 0 immediately; read CTRL -> 0x00.
REQ-035 SHALL verify a switch with SETTLE=4: write CTRL=0x01 with bus_idle=0 for 10 cycles -> speed_busy=1 and enable_16mhz=0 throughout; raise bus_idle -> enable_16mhz=1 the next cycle, then speed_busy=1 for 4 cycles, then 0.
REQ-036 SHALL verify cancellation: write 0x01 and then 0x00 while in WAIT_IDLE, then raise bus_idle -> enable_16mhz stays 0 and speed_busy drops.
REQ-037 SHALL verify flush: write CTRL=0x02 -> one cache_flush pulse and enable_cache=1; write 0x82 -> one pulse, CTRL reads 0x02; write 0x02 again -> no pulse.
REQ-038 SHALL verify register access with NREGS=3: write 0x5A to reg2 -> reads back 0x5A; write 0xFF to reg1 -> STATUS unchanged; read addr 3 -> 0x00.

Source files
------------

// File: rtl/mste_pkg.sv
// Shared register map, CTRL/STATUS bit positions and speed-sequencer state encoding.
package mste_pkg;

    localparam int unsigned DW = 8;

    localparam int unsigned REG_CTRL   = 0;
    localparam int unsigned REG_STATUS = 1;

    localparam int unsigned CTRL_SPEED = 0;
    localparam int unsigned CTRL_CACHE = 1;
    localparam int unsigned CTRL_FLUSH = 7;

    localparam int unsigned STAT_SPEED = 0;
    localparam int unsigned STAT_BUSY  = 1;
    localparam int unsigned STAT_REQ   = 2;

    localparam int unsigned CNT_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_IDLE = 2'd1,
        ST_SETTLE    = 2'd2
    } speed_state_e;

endpackage

// File: rtl/mste_speed_seq.sv
// CPU speed sequencer: waits for an idle bus before applying a speed change,
// then holds busy for SETTLE cycles.
module mste_speed_seq
    import mste_pkg::*;
#(
    parameter int unsigned SETTLE = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic req_16mhz,
    input  logic bus_idle,
    output logic enable_16mhz,
    output logic speed_busy
);

    speed_state_e     state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             en_d;
    logic             busy_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            enable_16mhz <= 1'b0;
            speed_busy   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            enable_16mhz <= en_d;
            speed_busy   <= busy_d;
        end
    end

    // A request that reverts while waiting for the bus is dropped without effect.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        en_d    = enable_16mhz;
        unique case (state_q)
            ST_IDLE: begin
                if (req_16mhz != enable_16mhz) state_d = ST_WAIT_IDLE;
            end
            ST_WAIT_IDLE: begin
                if (req_16mhz == enable_16mhz) begin
                    state_d = ST_IDLE;
                end else if (bus_idle) begin
                    en_d    = req_16mhz;
                    cnt_d   = CNT_W'(SETTLE - 1);
                    state_d = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (cnt_q == '0) state_d = ST_IDLE;
                else             cnt_d   = cnt_q - CNT_W'(1);
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

endmodule

// File: rtl/mste_sysctrl.sv
// System control block: CTRL/STATUS/scratch register bank, cache enable and
// flush pulse, plus the CPU speed sequencer.
module mste_sysctrl
    import mste_pkg::*;
#(
    parameter int unsigned NREGS  = 4,
    parameter int unsigned SETTLE = 4,
    localparam int unsigned AW    = (NREGS > 2) ? $clog2(NREGS) : 1
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [DW-1:0] din,
    input  logic [AW-1:0] addr,
    input  logic          sel,
    input  logic          rw,
    output logic [DW-1:0] dout,
    input  logic          bus_idle,
    output logic          enable_16mhz,
    output logic          enable_cache,
    output logic          cache_flush,
    output logic          speed_busy
);

    localparam int unsigned NSLOT = 1 << AW;
    localparam logic [AW:0] NREGS_W = (AW + 1)'(NREGS);

    logic [DW-2:0] ctrl_q;
    logic [DW-1:0] scratch_q [NSLOT];
    logic          addr_ok;
    logic          is_ctrl;
    logic          is_status;
    logic          ctrl_wr;

    assign addr_ok   = ({1'b0, addr} < NREGS_W);
    assign is_ctrl   = (addr == AW'(REG_CTRL));
    assign is_status = (addr == AW'(REG_STATUS));
    assign ctrl_wr   = sel && !rw && addr_ok && is_ctrl;

    assign enable_cache = ctrl_q[CTRL_CACHE];

    // CTRL bit7 is a write-1 flush strobe and is never stored.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ctrl_q      <= '0;
            cache_flush <= 1'b0;
            for (int i = 0; i < int'(NSLOT); i++) scratch_q[i] <= '0;
        end else begin
            cache_flush <= ctrl_wr &&
                           ((din[CTRL_CACHE] && !ctrl_q[CTRL_CACHE]) || din[CTRL_FLUSH]);
            if (sel && !rw && addr_ok) begin
                if (is_ctrl)         ctrl_q          <= din[DW-2:0];
                else if (!is_status) scratch_q[addr] <= din;
            end
        end
    end

    always_comb begin
        dout = '0;
        if (sel && rw && addr_ok) begin
            if (is_ctrl) begin
                dout = {1'b0, ctrl_q};
            end else if (is_status) begin
                dout[STAT_SPEED] = enable_16mhz;
                dout[STAT_BUSY]  = speed_busy;
                dout[STAT_REQ]   = ctrl_q[CTRL_SPEED];
            end else begin
                dout = scratch_q[addr];
            end
        end
    end

    mste_speed_seq #(
        .SETTLE (SETTLE)
    ) u_speed_seq (
        .clk          (clk),
        .reset_n      (reset_n),
        .req_16mhz    (ctrl_q[CTRL_SPEED]),
        .bus_idle     (bus_idle),
        .enable_16mhz (enable_16mhz),
        .speed_busy   (speed_busy)
    );

endmodule
